pipelined_addsub: RTL and testbench

//  - Parametrised, pipelined two's-complement adder/subtractor. Successor to the 4-bit ripple-carry adder.
//  - WIDTH-bit operands are split into STAGES equal chunks. Each pipeline stage adds one chunk, so the carry

---
 rtl/pipelined_addsub.sv | 105 ++++++++++
 tb/tb_pipelined_addsub.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one CW-bit chunk of carry per stage, global-stall handshake.
// Optional signed saturation of the result is enabled by defining ADDSUB_SAT_EN.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  // Each stage carries the whole word: unconsumed operand chunks, finished sum chunks and the chunk carry.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bp;
    logic [WIDTH-1:0] s;
    logic             c;
  } stage_t;

  stage_t            src   [STAGES];
  stage_t            st_d  [STAGES];
  stage_t            st_q  [STAGES];
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] valid_q;
  logic [CW:0]       part  [STAGES];
  logic [WIDTH-1:0]  raw_sum;
  logic              ovf_d;
  logic              ovf_q;
  logic              adv;

  assign adv       = !valid_q[STAGES-1] || out_ready;
  assign in_ready  = adv && rst_n;
  assign out_valid = valid_q[STAGES-1];
  assign sum       = st_q[STAGES-1].s;
  assign cout      = st_q[STAGES-1].c;
  assign ovf       = ovf_q;

  always_comb begin
    // NOTE: every signal gets a value on every path through this block, so no latches are inferred.
    src[0].a     = a;
    src[0].bp    = sub ? ~b : b;
    src[0].s     = '0;
    src[0].c     = sub ? ~cin : cin;
    src_valid[0] = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      src[k]       = st_q[k-1];
      src_valid[k] = valid_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      st_d[k] = src[k];
      part[k] = {1'b0, src[k].a[k*CW +: CW]} + {1'b0, src[k].bp[k*CW +: CW]} + {{CW{1'b0}}, src[k].c};
      st_d[k].s[k*CW +: CW] = part[k][CW-1:0];
      st_d[k].c             = part[k][CW];
    end
    valid_d = src_valid;

    raw_sum = st_d[STAGES-1].s;
    ovf_d   = (st_d[STAGES-1].a[WIDTH-1] == st_d[STAGES-1].bp[WIDTH-1]) &&
              (raw_sum[WIDTH-1] != st_d[STAGES-1].a[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
    // Clamp toward the sign of a; cout and ovf still describe the raw result.
    if (ovf_d) begin
      st_d[STAGES-1].s = st_d[STAGES-1].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                   : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif

    if (!adv) begin
      st_d    = st_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are cleared too, so the visible sum/cout/ovf read 0 after reset.
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
      valid_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every stage samples the previous-cycle state.
      st_q    <= st_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=16, STAGES=4): directed vectors, stalled stream,
// randomized handshake against a reference model, and mid-stream reset.
module tb_pipelined_addsub;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_checks = 0;
  int n_pass   = 0;

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    logic [15:0] bp;
    logic [16:0] full;
    logic        ov;
    logic [15:0] s;
    bp   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bp} + {16'b0, ms ? ~mc : mc};
    ov   = (ma[15] == bp[15]) && (full[15] != ma[15]);
    s    = full[15:0];
    if (SAT && ov) s = ma[15] ? 16'h8000 : 16'h7FFF;
    return {ov, full[16], s};
  endfunction

  // One isolated operation: measures latency and checks the hand-computed result.
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic vs, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    int lat;
    out_ready = 1'b1;
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    tick();
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  // Streams n ops. Directed mode: a=i, b=0x100*i with a 3-cycle stall at the first result.
  // Random mode: random operands and 50% in_valid/out_ready, checked against model().
  task automatic stream(input string tag, input int n, input bit rnd);
    logic [17:0] expq[$];
    logic [17:0] e;
    logic [15:0] va, vb;
    logic        vc, vs;
    int          sent = 0;
    int          got = 0;
    int          stall_left = 0;
    bit          stalled = 1'b0;
    for (int cyc = 0; cyc < 20 * n + 50 && got < n; cyc++) begin
      if (!rnd && out_valid && !stalled) begin
        stalled    = 1'b1;
        stall_left = 3;
      end
      if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
        va = 16'($urandom); vb = 16'($urandom);
        vc = 1'($urandom_range(0, 1)); vs = 1'($urandom_range(0, 1));
        in_valid = (sent < n) && ($urandom_range(0, 1) == 1);
      end else begin
        out_ready = (stall_left == 0);
        va = 16'(sent + 1); vb = 16'(32'h100 * (sent + 1)); vc = 1'b0; vs = 1'b0;
        in_valid = (sent < n);
      end
      a = va; b = vb; cin = vc; sub = vs;
      #1;
      if (stall_left > 0) begin
        check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_stall_hold"}, {14'd0, out_valid, cout, sum}, {14'd0, 1'b1, 1'b0, 16'h0101});
        stall_left--;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check({tag, "_extra_result"}, 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check({tag, "_result"}, {14'd0, ovf, cout, sum}, {14'd0, e});
        end
        got++;
      end
      if (in_valid && in_ready) begin
        if (rnd) expq.push_back(model(va, vb, vc, vs));
        else     expq.push_back({2'b00, 16'(32'h101 * (sent + 1))});
        sent++;
      end
      tick();
    end
    check({tag, "_count"}, 32'(got), 32'(n));
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", {15'd0, ovf, cout, sum}, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    run_op("carry_all",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);
    run_op("neg_ovf",    16'h8000, 16'h8000, 1'b0, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1);
    run_op("add_cin",    16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
    run_op("sub_borrow", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
    run_op("one_chunk",  16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    stream("stream", 8, 1'b0);
    stream("random", 500, 1'b1);

    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'(i + 1); b = 16'h1000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("midrst_flushed", 32'(seen), 32'd0);
    run_op("after_rst", 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
